// File: rtl/bcd_uart_tx.sv
// Serial report stage: snapshots three BCD digits on a send request and
// transmits "<h><t><u>\r\n" as five UART 8N1 frames on oTx.
module bcd_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic [3:0] iDigit1,
   input  logic [3:0] iDigit2,
   input  logic [3:0] iDigit3,
   input  logic       iSend,
   output logic       oTx,
   output logic       oBusy,
   output logic       oDone
);

   localparam int unsigned DIV_W    = $clog2(CLKS_PER_BIT);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_IDX = 3'd4;
   localparam logic [2:0]  LAST_BIT = 3'd7;
   localparam logic [7:0]  ASCII_CR = 8'h0D;
   localparam logic [7:0]  ASCII_LF = 8'h0A;
   localparam logic [7:0]  ASCII_Q  = 8'h3F;
   localparam logic [7:0]  ASCII_0  = 8'h30;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // Out-of-range digits are reported as '?'; the add is done at 8 bits.
   function automatic logic [7:0] to_ascii(input logic [3:0] d);
      logic [7:0] r;
      if (d > 4'd9) r = ASCII_Q;
      else          r = ASCII_0 + 8'(d);
      return r;
   endfunction

   function automatic logic [7:0] msg_byte(input logic [2:0] idx,
                                           input logic [3:0] d3,
                                           input logic [3:0] d2,
                                           input logic [3:0] d1);
      logic [7:0] r;
      case (idx)
         3'd0:    r = to_ascii(d3);
         3'd1:    r = to_ascii(d2);
         3'd2:    r = to_ascii(d1);
         3'd3:    r = ASCII_CR;
         default: r = ASCII_LF;
      endcase
      return r;
   endfunction

   state_t            state_q;
   logic [DIV_W-1:0]  div_q;
   logic [2:0]        bit_q;
   logic [2:0]        idx_q;
   logic [7:0]        shift_q;
   logic [3:0]        dig1_q;
   logic [3:0]        dig2_q;
   logic [3:0]        dig3_q;
   logic              tx_q;
   logic              busy_q;
   logic              done_q;

   logic              bit_end;
   logic [7:0]        first_byte;
   logic [7:0]        next_byte;

   // Byte 0 comes straight from the inputs; later bytes from the snapshot.
   always_comb begin
      bit_end    = (div_q == DIV_LAST);
      first_byte = msg_byte(3'd0, iDigit3, iDigit2, iDigit1);
      next_byte  = msg_byte(idx_q + 3'd1, dig3_q, dig2_q, dig1_q);
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         dig1_q  <= '0;
         dig2_q  <= '0;
         dig3_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               div_q  <= '0;
               bit_q  <= '0;
               if (iSend) begin
                  dig1_q  <= iDigit1;
                  dig2_q  <= iDigit2;
                  dig3_q  <= iDigit3;
                  idx_q   <= '0;
                  shift_q <= first_byte;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end

            S_START: begin
               if (bit_end) begin
                  div_q   <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= S_DATA;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            // LSB-first: the line always shows shift_q[0]; shift on each boundary.
            S_DATA: begin
               if (bit_end) begin
                  div_q <= '0;
                  if (bit_q == LAST_BIT) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            S_STOP: begin
               if (bit_end) begin
                  div_q <= '0;
                  if (idx_q == LAST_IDX) begin
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     shift_q <= next_byte;
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign oTx   = tx_q;
   assign oBusy = busy_q;
   assign oDone = done_q;

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Bench for bcd_uart_tx: waveform-level reference model compared every cycle,
// a mid-bit UART decoder, and directed scenarios with literal expectations.
module tb_bcd_uart_tx;

   localparam int C         = 4;
   localparam int FRAME_CYC = 50 * C;

   logic       iClk = 1'b0;
   logic       rst_n;
   logic [3:0] d1, d2, d3;
   logic       send;
   logic       tx, busy, done;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   always #5 iClk = ~iClk;

   bcd_uart_tx #(.CLKS_PER_BIT(C)) dut (
      .iClk    (iClk),
      .iRst_n  (rst_n),
      .iDigit1 (d1),
      .iDigit2 (d2),
      .iDigit3 (d3),
      .iSend   (send),
      .oTx     (tx),
      .oBusy   (busy),
      .oDone   (done)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Reference: the whole message as a 50-symbol line waveform.
   function automatic logic [7:0] ascii_of(input logic [3:0] d);
      if (d > 4'd9) return 8'h3F;
      return 8'h30 + 8'(d);
   endfunction

   function automatic logic [49:0] build_frame(input logic [3:0] h,
                                               input logic [3:0] t,
                                               input logic [3:0] u);
      logic [7:0]  b [5];
      logic [49:0] f;
      b[0] = ascii_of(h);
      b[1] = ascii_of(t);
      b[2] = ascii_of(u);
      b[3] = 8'h0D;
      b[4] = 8'h0A;
      for (int i = 0; i < 5; i++) begin
         f[i*10] = 1'b0;
         for (int k = 0; k < 8; k++) f[i*10+1+k] = b[i][k];
         f[i*10+9] = 1'b1;
      end
      return f;
   endfunction

   logic [49:0] m_frame;
   int          m_pos;
   bit          m_active;
   logic        exp_tx, exp_busy, exp_done;

   always @(posedge iClk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_pos    <= 0;
         exp_tx   <= 1'b1;
         exp_busy <= 1'b0;
         exp_done <= 1'b0;
      end else if (!m_active) begin
         exp_done <= 1'b0;
         if (send) begin
            m_frame  <= build_frame(d3, d2, d1);
            m_active <= 1'b1;
            m_pos    <= 0;
            exp_tx   <= 1'b0;
            exp_busy <= 1'b1;
         end else begin
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
         end
      end else if (m_pos == FRAME_CYC - 1) begin
         m_active <= 1'b0;
         exp_tx   <= 1'b1;
         exp_busy <= 1'b0;
         exp_done <= 1'b1;
      end else begin
         m_pos  <= m_pos + 1;
         exp_tx <= m_frame[(m_pos + 1) / C];
      end
   end

   initial forever begin
      @(negedge iClk);
      if (cmp_en)
         check("outputs_vs_model", int'({tx, busy, done}),
               int'({exp_tx, exp_busy, exp_done}));
   end

   // Mid-bit UART decoder.
   logic [7:0] rx_q [$];
   bit         rx_active = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh = '0;

   initial forever begin
      @(negedge iClk);
      if (!rst_n) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (tx == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == C / 2) begin
            check("start_bit_mid", int'(tx), 0);
         end else if (rx_cnt >= C + C / 2 && rx_cnt < 9 * C &&
                      (rx_cnt - C / 2) % C == 0) begin
            rx_sh[(rx_cnt - C - C / 2) / C] = tx;
         end else if (rx_cnt == 9 * C + C / 2) begin
            check("stop_bit_mid", int'(tx), 1);
            rx_q.push_back(rx_sh);
            rx_active = 1'b0;
         end
      end
   end

   // Busy run lengths, idle gaps and done pulses.
   int   done_cnt = 0, busy_run = 0, low_run = 0, last_busy_len = 0, last_gap = 0;
   logic prev_busy = 1'b0;

   initial forever begin
      @(negedge iClk);
      if (done) done_cnt++;
      if (busy) begin
         if (!prev_busy) last_gap = low_run;
         busy_run++;
         low_run = 0;
      end else begin
         if (prev_busy) last_busy_len = busy_run;
         busy_run = 0;
         low_run++;
      end
      prev_busy = busy;
   end

   task automatic send_pulse(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
      @(posedge iClk); #1;
      d3 = h; d2 = t; d1 = u;
      send = 1'b1;
      @(posedge iClk); #1;
      send = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < FRAME_CYC + 100 && !seen; i++) begin
         @(negedge iClk);
         if (done) seen = 1'b1;
      end
      check({name, "_done_seen"}, int'(seen), 1);
      @(posedge iClk); #1;
   endtask

   task automatic expect_msg(input string name, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] e [5];
      e = '{b0, b1, b2, 8'h0D, 8'h0A};
      for (int i = 0; i < 5; i++) begin
         if (rx_q.size() == 0) check({name, "_byte_missing"}, 0, 1);
         else                  check({name, "_byte"}, int'(rx_q.pop_front()), int'(e[i]));
      end
   endtask

   initial begin
      int dc0;
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc0;
      rst_n = 1'b0;
      send  = 1'b0;
      d1 = '0; d2 = '0; d3 = '0;
      repeat (3) @(posedge iClk);
      #1;
      check("rst_tx", int'(tx), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(posedge iClk);

      // 123 with single-cycle request
      dc0 = done_cnt;
      send_pulse(4'd1, 4'd2, 4'd3);
      check("t1_tx_fall", int'(tx), 0);
      check("t1_busy_rise", int'(busy), 1);
      wait_done("t1");
      expect_msg("t1", 8'h31, 8'h32, 8'h33);
      check("t1_busy_len", last_busy_len, 200);
      check("t1_done_cnt", done_cnt - dc0, 1);
      check("t1_tx_idle", int'(tx), 1);

      // boundary digits
      send_pulse(4'd0, 4'd0, 4'd0);
      wait_done("t2a");
      expect_msg("t2a", 8'h30, 8'h30, 8'h30);
      repeat (3) begin
         @(posedge iClk); #1;
         check("t2_gap_tx_high", int'(tx), 1);
      end
      send_pulse(4'd9, 4'd9, 4'd9);
      wait_done("t2b");
      expect_msg("t2b", 8'h39, 8'h39, 8'h39);

      // non-BCD digits
      send_pulse(4'hF, 4'hB, 4'h0);
      wait_done("t3");
      expect_msg("t3", 8'h3F, 8'h3F, 8'h30);

      // snapshot isolation and request while busy
      dc0 = done_cnt;
      send_pulse(4'd4, 4'd5, 4'd6);
      repeat (58) @(posedge iClk);
      #1;
      d3 = 4'd7; d2 = 4'd8; d1 = 4'd9;
      send = 1'b1;
      @(posedge iClk); #1;
      send = 1'b0;
      check("t4_still_busy", int'(busy), 1);
      wait_done("t4");
      expect_msg("t4", 8'h34, 8'h35, 8'h36);
      repeat (10) @(posedge iClk);
      #1;
      check("t4_no_second_msg", int'(busy), 0);
      check("t4_queue_empty", rx_q.size(), 0);
      check("t4_one_done", done_cnt - dc0, 1);

      // asynchronous reset mid-DATA of byte 1
      dc0 = done_cnt;
      send_pulse(4'd8, 4'd6, 4'd2);
      repeat (55) @(posedge iClk);
      #3;
      rst_n = 1'b0;
      #1;
      check("t5_tx_async", int'(tx), 1);
      check("t5_busy_async", int'(busy), 0);
      check("t5_done_async", int'(done), 0);
      repeat (2) @(posedge iClk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge iClk);
      #1;
      check("t5_no_done", done_cnt - dc0, 0);
      check("t5_no_resume", int'(busy), 0);
      check("t5_partial_bytes", rx_q.size(), 1);
      if (rx_q.size() > 0) check("t5_byte0", int'(rx_q.pop_front()), 8'h38);
      rx_q.delete();
      dc0 = done_cnt;
      send_pulse(4'd3, 4'd1, 4'd4);
      wait_done("t5b");
      expect_msg("t5b", 8'h33, 8'h31, 8'h34);
      check("t5b_done_cnt", done_cnt - dc0, 1);

      // request held high for 450 cycles: back-to-back with 1 idle cycle
      dc0 = done_cnt;
      @(posedge iClk); #1;
      d3 = 4'd2; d2 = 4'd0; d1 = 4'd7;
      send = 1'b1;
      repeat (250) @(posedge iClk);
      #1;
      check("t6_gap", last_gap, 1);
      check("t6_first_done", done_cnt - dc0, 1);
      expect_msg("t6a", 8'h32, 8'h30, 8'h37);
      repeat (200) @(posedge iClk);
      #1;
      send = 1'b0;
      check("t6_two_done", done_cnt - dc0, 2);
      expect_msg("t6b", 8'h32, 8'h30, 8'h37);
      // a third acceptance fell inside the hold window; drain it
      wait_done("t6c");
      expect_msg("t6c", 8'h32, 8'h30, 8'h37);
      check("t6_gap2", last_gap, 1);
      check("t6_total_done", done_cnt - dc0, 3);

      repeat (5) @(posedge iClk);
      #1;
      check("end_queue_empty", rx_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
